// File: rtl/call_ret_sequencer.sv
// Call/return/interrupt sequencer: arbitrates JMS, BBL and IRQ requests and
// drives the return-address stack and PC-load strobes, latching over/underflow faults.
module call_ret_sequencer #(
   parameter logic [2:0] SP_MAX = 3'd7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        call_req,
   input  logic [11:0] call_target,
   input  logic [11:0] call_ret_addr,
   input  logic        ret_req,
   input  logic        ret_irq,
   input  logic        irq_req,
   input  logic [11:0] irq_vector,
   input  logic [11:0] irq_ret_addr,
   input  logic        fault_clr,
   output logic        stk_push,
   output logic        stk_pop,
   output logic [11:0] stk_pc_in,
   input  logic [11:0] stk_pc_out,
   input  logic [2:0]  stk_sp,
   output logic        call_ack,
   output logic        ret_ack,
   output logic        irq_ack,
   output logic        pc_load,
   output logic [11:0] pc_load_val,
   output logic        busy,
   output logic        in_isr,
   output logic        fault,
   output logic [1:0]  fault_code
);

   typedef enum logic [2:0] {IDLE, PUSH, POP, LOAD, FAULT} state_t;

   state_t      r_state;
   logic        r_stk_push;
   logic        r_stk_pop;
   logic        r_pc_load;
   logic        r_busy;
   logic        r_in_isr;
   logic        r_fault;
   logic [1:0]  r_fault_code;
   logic [11:0] r_target;
   logic [11:0] r_ret_addr;
   logic        r_is_ret;
   logic        r_ret_irq;

   logic w_idle;
   logic w_irq_win;
   logic w_call_win;
   logic w_ret_win;

   // Acks must pulse in the accepting IDLE cycle, so arbitration is combinational.
   assign w_idle     = (r_state == IDLE) && rst_n;
   assign w_irq_win  = w_idle && irq_req && !r_in_isr;
   assign w_call_win = w_idle && call_req && !w_irq_win;
   assign w_ret_win  = w_idle && ret_req && !w_irq_win && !call_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_stk_push   <= 1'b0;
         r_stk_pop    <= 1'b0;
         r_pc_load    <= 1'b0;
         r_busy       <= 1'b0;
         r_in_isr     <= 1'b0;
         r_fault      <= 1'b0;
         r_fault_code <= 2'b00;
         r_target     <= '0;
         r_ret_addr   <= '0;
         r_is_ret     <= 1'b0;
         r_ret_irq    <= 1'b0;
      end else begin
         r_stk_push <= 1'b0;
         r_stk_pop  <= 1'b0;
         r_pc_load  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_irq_win || w_call_win) begin
                  r_target   <= w_irq_win ? irq_vector : call_target;
                  r_ret_addr <= w_irq_win ? irq_ret_addr : call_ret_addr;
                  r_is_ret   <= 1'b0;
                  r_busy     <= 1'b1;
                  if (stk_sp >= SP_MAX) begin
                     r_state      <= FAULT;
                     r_fault      <= 1'b1;
                     r_fault_code <= 2'b01;
                  end else begin
                     r_state    <= PUSH;
                     r_stk_push <= 1'b1;
                     if (w_irq_win) r_in_isr <= 1'b1;
                  end
               end else if (w_ret_win) begin
                  r_is_ret  <= 1'b1;
                  r_ret_irq <= ret_irq;
                  r_busy    <= 1'b1;
                  if (stk_sp == '0) begin
                     r_state      <= FAULT;
                     r_fault      <= 1'b1;
                     r_fault_code <= 2'b10;
                  end else begin
                     r_state   <= POP;
                     r_stk_pop <= 1'b1;
                  end
               end
            end
            PUSH: begin
               r_state   <= LOAD;
               r_pc_load <= 1'b1;
            end
            POP: begin
               r_state   <= LOAD;
               r_pc_load <= 1'b1;
               if (r_ret_irq) r_in_isr <= 1'b0;
            end
            LOAD: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            FAULT: begin
               if (fault_clr) begin
                  r_state      <= IDLE;
                  r_busy       <= 1'b0;
                  r_fault      <= 1'b0;
                  r_fault_code <= 2'b00;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Return data is taken straight from the stack, which registers it on the pop edge.
   assign pc_load_val = (r_pc_load && r_is_ret) ? stk_pc_out : r_target;
   assign stk_pc_in   = r_ret_addr;
   assign stk_push    = r_stk_push;
   assign stk_pop     = r_stk_pop;
   assign pc_load     = r_pc_load;
   assign call_ack    = w_call_win;
   assign ret_ack     = w_ret_win;
   assign irq_ack     = w_irq_win;
   assign busy        = r_busy;
   assign in_isr      = r_in_isr;
   assign fault       = r_fault;
   assign fault_code  = r_fault_code;

endmodule

// File: tb/tb_call_ret_sequencer.sv
// Scoreboard bench for call_ret_sequencer: driver predicts events from a
// queue-based stack model, monitor pops and compares them as the DUT emits them.
module tb_call_ret_sequencer;

   localparam int SPMAX = 7;
   localparam int K_ACKC = 0, K_ACKR = 1, K_ACKI = 2, K_PUSH = 3, K_POP = 4, K_LOAD = 5, K_FAULT = 6;
   localparam int W_NONE = 0, W_CALL = 1, W_RET = 2, W_IRQ = 3;

   typedef struct {
      int          kind;
      logic [11:0] val;
      int          off;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        call_req = 1'b0, ret_req = 1'b0, ret_irq = 1'b0, irq_req = 1'b0, fault_clr = 1'b0;
   logic [11:0] call_target = '0, call_ret_addr = '0, irq_vector = '0, irq_ret_addr = '0;
   logic        stk_push, stk_pop, call_ack, ret_ack, irq_ack, pc_load, busy, in_isr, fault;
   logic [11:0] stk_pc_in, pc_load_val;
   logic [1:0]  fault_code;
   logic [11:0] stk_pc_out;
   logic [2:0]  stk_sp;

   // External return-address stack the sequencer controls
   logic [11:0] mem [8];
   logic [2:0]  env_sp = '0;
   logic [11:0] env_out = '0;
   assign stk_pc_out = env_out;
   assign stk_sp     = env_sp;

   always @(posedge clk) begin
      if (stk_push) begin
         mem[env_sp] <= stk_pc_in;
         env_sp      <= env_sp + 3'd1;
      end else if (stk_pop) begin
         env_out <= mem[env_sp - 3'd1];
         env_sp  <= env_sp - 3'd1;
      end
   end

   call_ret_sequencer #(.SP_MAX(3'd7)) dut (
      .clk(clk), .rst_n(rst_n),
      .call_req(call_req), .call_target(call_target), .call_ret_addr(call_ret_addr),
      .ret_req(ret_req), .ret_irq(ret_irq),
      .irq_req(irq_req), .irq_vector(irq_vector), .irq_ret_addr(irq_ret_addr),
      .fault_clr(fault_clr),
      .stk_push(stk_push), .stk_pop(stk_pop), .stk_pc_in(stk_pc_in),
      .stk_pc_out(stk_pc_out), .stk_sp(stk_sp),
      .call_ack(call_ack), .ret_ack(ret_ack), .irq_ack(irq_ack),
      .pc_load(pc_load), .pc_load_val(pc_load_val),
      .busy(busy), .in_isr(in_isr), .fault(fault), .fault_code(fault_code)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          ack_cyc = 0;
   logic        prev_fault = 1'b0;
   ev_t         exp_q[$];
   logic [11:0] m_stack[$];
   bit          m_isr = 1'b0;

   function automatic void push_exp(input int kind, input logic [11:0] val, input int off);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      e.off  = off;
      exp_q.push_back(e);
   endfunction

   function automatic int winner(input bit c, input bit r, input bit i);
      if (i && !m_isr) return W_IRQ;
      if (c) return W_CALL;
      if (r) return W_RET;
      return W_NONE;
   endfunction

   task automatic predict(input int w, input bit rirq, input logic [11:0] tgt, input logic [11:0] ra,
                          input logic [11:0] vec, input logic [11:0] iret, output bit flt);
      flt = 1'b0;
      if (w == W_IRQ || w == W_CALL) begin
         push_exp((w == W_IRQ) ? K_ACKI : K_ACKC, 12'h000, 0);
         if (m_stack.size() < SPMAX) begin
            push_exp(K_PUSH, (w == W_IRQ) ? iret : ra, 1);
            push_exp(K_LOAD, (w == W_IRQ) ? vec : tgt, 2);
            m_stack.push_back((w == W_IRQ) ? iret : ra);
            if (w == W_IRQ) m_isr = 1'b1;
         end else begin
            push_exp(K_FAULT, 12'h001, 1);
            flt = 1'b1;
         end
      end else if (w == W_RET) begin
         push_exp(K_ACKR, 12'h000, 0);
         if (m_stack.size() > 0) begin
            push_exp(K_POP, 12'h000, 1);
            push_exp(K_LOAD, m_stack.pop_back(), 2);
            if (rirq) m_isr = 1'b0;
         end else begin
            push_exp(K_FAULT, 12'h002, 1);
            flt = 1'b1;
         end
      end
   endtask

   task automatic see(input int kind, input logic [11:0] val);
      ev_t e;
      if (kind <= K_ACKI) ack_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind=%0d val=%h, required no event", kind, val);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val != val || (cyc - ack_cyc) != e.off) begin
            errors++;
            $display("FAIL event: got kind=%0d val=%h off=%0d, required kind=%0d val=%h off=%0d",
                     kind, val, cyc - ack_cyc, e.kind, e.val, e.off);
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         cyc++;
         if (call_ack) see(K_ACKC, 12'h000);
         if (ret_ack)  see(K_ACKR, 12'h000);
         if (irq_ack)  see(K_ACKI, 12'h000);
         if (stk_push) see(K_PUSH, stk_pc_in);
         if (stk_pop)  see(K_POP, 12'h000);
         if (pc_load)  see(K_LOAD, pc_load_val);
         if (fault && !prev_fault) see(K_FAULT, {10'd0, fault_code});
         if (stk_push || stk_pop || pc_load)
            chk("strobe_exclusive", int'(stk_push) + int'(stk_pop) + int'(pc_load), 1);
      end
      prev_fault <= fault;
   end

   task automatic run_op(input bit c, input bit r, input bit i, input bit rirq,
                         input logic [11:0] tgt, input logic [11:0] ra,
                         input logic [11:0] vec, input logic [11:0] iret, input bit hold_in);
      int w, n;
      bit flt, more, hold, skip_wait;
      hold = hold_in;
      @(posedge clk); #1;
      call_req = c; ret_req = r; irq_req = i; ret_irq = rirq;
      call_target = tgt; call_ret_addr = ra; irq_vector = vec; irq_ret_addr = iret;
      w = winner(c, r, i);
      if (w == W_NONE) begin
         repeat (3) @(negedge clk);
         call_req = 1'b0; ret_req = 1'b0; irq_req = 1'b0;
         chk("ignored_req_busy", int'(busy), 0);
         return;
      end
      predict(w, rirq, tgt, ra, vec, iret, flt);
      more = 1'b1;
      skip_wait = 1'b0;
      while (more) begin
         more = 1'b0;
         n = 0;
         if (!skip_wait) @(negedge clk);
         while (!(call_ack || ret_ack || irq_ack) && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (n >= 20) begin
            chk("ack_timeout", n, 0);
            exp_q.delete();
            call_req = 1'b0; ret_req = 1'b0; irq_req = 1'b0;
            return;
         end
         @(posedge clk); #1;
         call_target = 12'($urandom); call_ret_addr = 12'($urandom);
         irq_vector = 12'($urandom); irq_ret_addr = 12'($urandom);
         if (!(hold && flt)) begin
            call_req = 1'b0; ret_req = 1'b0; irq_req = 1'b0; ret_irq = 1'($urandom);
         end
         @(negedge clk);
         n = 1;
         while (busy && !fault && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (flt) begin
            chk("fault_latency", n, 1);
            chk("fault_busy_held", int'(busy), 1);
            if (hold) begin
               predict(winner(call_req, ret_req, irq_req), ret_irq, call_target, call_ret_addr,
                       irq_vector, irq_ret_addr, flt);
               more = 1'b1;
               hold = 1'b0;
               skip_wait = 1'b1;
            end
            @(posedge clk); #1 fault_clr = 1'b1;
            @(posedge clk); #1 fault_clr = 1'b0;
            @(negedge clk);
            chk("fault_cleared", int'({fault, fault_code}), 0);
            if (!more) chk("busy_after_clr", int'(busy), 0);
         end else begin
            chk("busy_low_at_T3", n, 3);
         end
      end
      chk("in_isr", int'(in_isr), int'(m_isr));
      chk("stack_depth", int'(stk_sp), m_stack.size());
   endtask

   task automatic reset_mid_push();
      bit flt;
      @(posedge clk); #1;
      call_req = 1'b1; call_target = 12'hABC; call_ret_addr = 12'h123;
      push_exp(K_ACKC, 12'h000, 0);
      @(negedge clk);
      chk("reset_test_ack", int'(call_ack), 1);
      @(posedge clk); #2;
      chk("push_before_reset", int'(stk_push), 1);
      rst_n = 1'b0;
      #1;
      chk("outputs_in_reset", int'({call_ack, ret_ack, irq_ack, stk_push, stk_pop, pc_load, pc_load_val,
                                    stk_pc_in, busy, in_isr, fault, fault_code}), 0);
      call_req = 1'b0;
      m_isr = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("no_load_after_reset", exp_q.size(), 0);
      chk("stack_after_reset", int'(stk_sp), m_stack.size());
      flt = 1'b0;
      if (flt) chk("unused", 0, 0);
   endtask

   initial begin
      bit c, r, i, ri;
      int sel;
      #1;
      chk("reset_outputs", int'({call_ack, ret_ack, irq_ack, stk_push, stk_pop, pc_load, pc_load_val,
                                 stk_pc_in, busy, in_isr, fault, fault_code}), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      run_op(1, 0, 0, 0, 12'h3A0, 12'h102, 12'h000, 12'h000, 0);
      run_op(0, 1, 0, 0, 12'h000, 12'h000, 12'h000, 12'h000, 0);
      run_op(1, 1, 1, 0, 12'h777, 12'h888, 12'h004, 12'h055, 0);
      run_op(0, 0, 1, 0, 12'h000, 12'h000, 12'h010, 12'h020, 0);
      run_op(0, 1, 0, 1, 12'h000, 12'h000, 12'h000, 12'h000, 0);
      run_op(0, 1, 0, 0, 12'h000, 12'h000, 12'h000, 12'h000, 0);
      for (int k = 0; k < 7; k++)
         run_op(1, 0, 0, 0, 12'($urandom), 12'($urandom), 12'h000, 12'h000, 0);
      run_op(1, 0, 0, 0, 12'h5A5, 12'hA5A, 12'h000, 12'h000, 1);
      run_op(0, 0, 1, 0, 12'h000, 12'h000, 12'h004, 12'h066, 0);

      for (int k = 0; k < 250; k++) begin
         sel = $urandom_range(0, 9);
         c = (sel <= 3); r = (sel >= 4 && sel <= 6) || sel == 9; i = (sel == 7); ri = (sel == 9);
         if (sel == 8) begin
            c = 1'($urandom); r = 1'($urandom); i = 1'($urandom); ri = 1'($urandom);
         end
         run_op(c, r, i, ri, 12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 0);
         if (k == 120) begin
            if (m_stack.size() >= SPMAX) run_op(0, 1, 0, 0, 12'h000, 12'h000, 12'h000, 12'h000, 0);
            reset_mid_push();
         end
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1);
   end

endmodule

// File: doc/call_ret_sequencer.md
CALL_RET_SEQUENCER -- requirements
Module: call_ret_sequencer

Interface
REQ-001 Parameter SP_MAX, default 3'd7: highest legal stack pointer; a push at this depth is refused.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 call_req  in  1  level request for a subroutine call (JMS); held by the requester until call_ack.
REQ-005 call_target  in  12  call destination address.
REQ-006 call_ret_addr  in  12  return address pushed on a call.
REQ-007 ret_req  in  1  level request for a return (BBL); held until ret_ack.
REQ-008 ret_irq  in  1  qualifies ret_req as return-from-interrupt; sampled with ret_req.
REQ-009 irq_req  in  1  level interrupt request.
REQ-010 irq_vector  in  12  interrupt entry address.
REQ-011 irq_ret_addr  in  12  address pushed on interrupt entry.
REQ-012 fault_clr  in  1  clears a latched fault.
REQ-013 stk_push / stk_pop  out  1 each  one-cycle strobes to the 8-level return-address stack.
REQ-014 stk_pc_in  out  12  push data.
REQ-015 stk_pc_out  in  12  pop data; registered by the stack on the pop edge.
REQ-016 stk_sp  in  3  current stack pointer.
REQ-017 call_ack / ret_ack / irq_ack  out  1 each  one-cycle acceptance pulses.
REQ-018 pc_load  out  1  one-cycle strobe; the PC loads pc_load_val.
REQ-019 pc_load_val  out  12  new PC value.
REQ-020 busy  out  1  high whenever the state is not IDLE.
REQ-021 in_isr  out  1  interrupt-service flag.
REQ-022 fault  out  1  latched over/underflow fault.
REQ-023 fault_code  out  2  01 = overflow, 10 = underflow, 00 = none.

Function
REQ-024 The state machine shall have the states IDLE, PUSH, POP, LOAD and FAULT.
REQ-025 In IDLE, requests shall be arbitrated with priority irq_req (only when in_isr=0) > call_req > ret_req.
- Exactly one ack pulses, in the accepting IDLE cycle.
- Non-winning requests are ignored and must be held.
REQ-026 For an accepted call or irq with stk_sp < SP_MAX, the next state shall be PUSH.
- PUSH drives stk_push=1 and stk_pc_in = latched return address.
- The following cycle is LOAD: pc_load=1, pc_load_val = latched target (irq_vector for an interrupt).
- Then back to IDLE.
- Total: 3 cycles from ack to IDLE.
REQ-027 Interrupt acceptance shall set in_isr in the ack cycle.
REQ-028 For an accepted ret with stk_sp > 0, the next state shall be POP.
- POP drives stk_pop=1.
- Next state is LOAD, with pc_load_val = stk_pc_out sampled in that cycle.
- in_isr is cleared in LOAD if ret_irq was latched as 1.
REQ-029 An accepted call/irq with stk_sp == SP_MAX shall produce no push and no pc_load.
- Next state is FAULT, with fault=1 and fault_code=01.
- in_isr is left unchanged on a refused irq.
REQ-030 An accepted ret with stk_sp == 0 shall produce no pop and no pc_load.
- Next state is FAULT, with fault=1 and fault_code=10.
REQ-031 FAULT shall hold busy=1 and ignore all requests.
- fault_clr returns to IDLE next cycle and clears fault/fault_code.
- Held requests are then re-arbitrated.
REQ-032 Targets, return addresses and the ret_irq qualifier shall be latched in the ack cycle.
- Input changes after ack have no effect.
REQ-033 stk_push, stk_pop and pc_load shall never be asserted in the same cycle.
- Each shall be high for exactly one cycle per operation.
REQ-034 Address arithmetic shall not be performed; all addresses pass through unmodified at 12 bits.

Reset
REQ-035 While rst_n=0, the block shall force the following, independent of clk:
- state=IDLE;
- all strobes and acks = 0;
- pc_load_val=12'h000 and stk_pc_in=12'h000;
- busy=0, in_isr=0, fault=0, fault_code=00.
REQ-036 Reset asserted mid-operation shall abort it with no further strobes.
- Operation resumes only by re-arbitration after rst_n rises.

Verification
REQ-037 call_req, target=12'h3A0, ret_addr=12'h102, sp=0:
- call_ack at T0;
- stk_push with stk_pc_in=102 at T1;
- pc_load with 3A0 at T2;
- busy low at T3.
REQ-038 ret_req with sp=1 and stack top 12'h102:
- stk_pop at T1;
- pc_load with 102 at T2.
REQ-039 irq_req, call_req and ret_req together, in_isr=0, vector=12'h004:
- only irq_ack fires;
- in_isr=1;
- pc_load with 004.
- A second irq while in_isr=1 is ignored.
- ret_req with ret_irq=1 clears in_isr in LOAD.
REQ-040 call_req with sp=7:
- no stk_push and no pc_load;
- fault=1, code=01, busy held.
- After fault_clr, the still-held call_req is re-acked.
REQ-041 ret_req with sp=0: fault=1, code=10, no stk_pop.
REQ-042 rst_n low during PUSH:
- all outputs go to reset values immediately;
- no pc_load follows.
